// File: rtl/uart_pkg.sv
// Shared types and bit-rate arithmetic for the buffered UART transmitter.
// The receive path uses the same arithmetic, so both ends agree on the bit period.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

    function automatic int clk_per_bit(input real sysclk, input real baud);
        return int'(sysclk / baud);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock byte FIFO. Pointers carry one extra wrap bit so that full and
// empty are told apart. A reset flushes all stored entries.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pushes while full and pops while empty are dropped here.
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_tx_fifo_ser.sv
// Buffered UART transmitter: bytes pushed via valid/ready land in a FIFO and
// leave LSB first as 8N1/8N2 frames, back-to-back while the FIFO has data.
module uart_tx_fifo_ser
    import uart_pkg::*;
#(
    parameter real SYSCLOCK   = 27.0,
    parameter real BAUDRATE   = 1.0,
    parameter int  FIFO_DEPTH = 16,
    parameter int  STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       tx,
    output logic       tx_bsy,
    output logic       tx_done,
    output logic       fifo_empty
);

    localparam int CLKPERBIT = clk_per_bit(SYSCLOCK, BAUDRATE);
    localparam int TW        = $clog2(CLKPERBIT * STOP_BITS) + 1;
    localparam logic [TW-1:0] BIT_END  = TW'(CLKPERBIT - 1);
    localparam logic [TW-1:0] STOP_END = TW'(CLKPERBIT * STOP_BITS - 1);

    if (CLKPERBIT < 2) begin : g_bad_rate
        $error("uart_tx_fifo_ser: SYSCLOCK/BAUDRATE gives fewer than 2 clocks per bit");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx_fifo_ser: STOP_BITS must be 1 or 2");
    end

    uart_tx_state_t state;
    logic [TW-1:0]  timer;
    logic [2:0]     bit_idx;
    logic [7:0]     shreg;
    logic [7:0]     head;
    logic           full;
    logic           empty;
    logic           pop;

    // A pop happens on the IDLE->START edge and on the last stop-bit edge,
    // so consecutive frames start with no idle cycle in between.
    assign pop        = !empty && ((state == IDLE) || (state == STOP && timer == STOP_END));
    assign data_ready = !full;
    assign fifo_empty = empty;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (data_valid),
        .push_data (data_in),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
            tx_bsy  <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        shreg  <= head;
                        tx     <= 1'b0;
                        tx_bsy <= 1'b1;
                        timer  <= '0;
                        state  <= START;
                    end
                end
                START: begin
                    if (timer == BIT_END) begin
                        timer   <= '0;
                        tx      <= shreg[0];
                        shreg   <= {1'b0, shreg[7:1]};
                        bit_idx <= '0;
                        state   <= DATA;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DATA: begin
                    if (timer == BIT_END) begin
                        timer   <= '0;
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            tx    <= shreg[0];
                            shreg <= {1'b0, shreg[7:1]};
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                STOP: begin
                    if (timer == STOP_END) begin
                        timer   <= '0;
                        tx_done <= 1'b1;
                        if (!empty) begin
                            shreg <= head;
                            tx    <= 1'b0;
                            state <= START;
                        end else begin
                            tx_bsy <= 1'b0;
                            state  <= IDLE;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
